digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_pkg.sv | 12 +
 rtl/fa_cell.sv | 16 +
 rtl/digit_serial_adder.sv | 143 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_pkg.sv
// digit_serial_pkg
//   Shared types for the digit-serial adder.
//   state_t : controller state, 2-bit encoding (IDLE, RUN, DONE).
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// fa_cell
//   One-bit full adder. The top module cascades DIGIT of these into the
//   per-cycle ripple chain.
//   Ports: a, b, cin (in)  -> sum, carry (out)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder: adds two WIDTH-bit operands DIGIT bits per clock
//   through a ripple chain of fa_cell instances, holding the inter-digit
//   carry in a register. One operation is launched with start and reported
//   with a one-cycle done pulse; sum/cout/overflow hold until the next
//   operation completes.
//
//   Optional build macro: ADDER_SUB_EN adds the sub port (A - B when set).
//
//   Parameters: WIDTH (>= 2), DIGIT (divides WIDTH)
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start             launch request, honoured only when not busy
//     a, b, cin         operands and carry-in, captured on accepted start
//     sub               subtract select (ADDER_SUB_EN builds only)
//     busy              operation in progress
//     done              one-cycle pulse, results just updated
//     sum, cout         result and carry out of the MSB
//     overflow          signed overflow of the last operation
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start, results held
//   RUN   | one digit per cycle, cnt counts digits already issued
//   DONE  | done pulse; start here launches back-to-back
module digit_serial_adder
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] sum_nxt;
  logic             sub_eff;

`ifdef ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a    (a_sr[i]),
      .b    (b_sr[i]),
      .cin  (c[i]),
      .sum  (dsum[i]),
      .carry(c[i+1])
    );
  end

  // The partial-sum register only needs the digits already produced, so it
  // is WIDTH-DIGIT wide; with a single digit there is nothing to keep.
  if (NDIG == 1) begin : g_one_digit
    assign sum_nxt = dsum;
  end else begin : g_multi_digit
    logic [WIDTH-DIGIT-1:0] psum;

    assign sum_nxt = {dsum, psum};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        psum <= '0;
      end else if (state == RUN) begin
        psum <= sum_nxt[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            a_sr  <= a;
            // Subtraction as A + ~B + 1; cin is ignored in that mode.
            b_sr  <= sub_eff ? ~b : b;
            carry <= sub_eff | cin;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          carry <= c[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            sum      <= sum_nxt;
            cout     <= c[DIGIT];
            // c[DIGIT-1] is the carry into the top bit of the final digit.
            overflow <= c[DIGIT] ^ c[DIGIT-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

`ifdef ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cin   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic [7:0]  a8    = '0;
  logic [7:0]  b8    = '0;
  logic        sub8  = 1'b0;

  logic        busy_v [5];
  logic        done_v [5];
  logic        cout_v [5];
  logic        ovf_v  [5];
  logic [15:0] sum_v  [5];

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // WIDTH=16 with DIGIT = 1, 2, 4, 8, 16
  for (genvar g = 0; g < 5; g++) begin : g_dut
    digit_serial_adder #(.WIDTH(16), .DIGIT(1 << g)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
`ifdef ADDER_SUB_EN
      .sub     (1'b0),
`endif
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .sum     (sum_v[g]),
      .cout    (cout_v[g]),
      .overflow(ovf_v[g])
    );
  end

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a8),
    .b       (b8),
    .cin     (cin),
`ifdef ADDER_SUB_EN
    .sub     (sub8),
`endif
    .busy    (busy8),
    .done    (done8),
    .sum     (sum8),
    .cout    (cout8),
    .overflow(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {overflow, cout, sum} from integer arithmetic
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    int unsigned u;
    int          s;
    u = 32'(x) + 32'(y) + 32'(ci);
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    return {(s > 32767 || s < -32768), u[16], u[15:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                      input logic ci, input logic sb);
    int unsigned u;
    int          s;
    logic [7:0]  yy;
    yy = sb ? ~y : y;
    u  = 32'(x) + 32'(yy) + (sb ? 32'd1 : 32'(ci));
    s  = sb ? int'($signed(x)) - int'($signed(y))
            : int'($signed(x)) + int'($signed(y)) + int'(ci);
    return {(s > 127 || s < -128), u[8], u[7:0]};
  endfunction

  // Launch one operation on all instances and check latency and results.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic [7:0] x8, input logic [7:0] y8, input logic sb);
    int          lat [6];
    logic [17:0] e16;
    logic [9:0]  e8;
    a = x; b = y; cin = ci; a8 = x8; b8 = y8; sub8 = sb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int g = 0; g < 5; g++) chk($sformatf("busy_d%0d", 1 << g), 32'(busy_v[g]), 32'd1);
    chk("busy_w8", 32'(busy8), 32'd1);
    for (int g = 0; g < 6; g++) lat[g] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 5; g++) if (done_v[g] && lat[g] == 0) lat[g] = k;
      if (done8 && lat[5] == 0) lat[5] = k;
    end
    e16 = ref16(x, y, ci);
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("lat_d%0d", 1 << g), 32'(lat[g]), 32'(16 >> g));
      chk($sformatf("sum_d%0d", 1 << g), 32'(sum_v[g]), 32'(e16[15:0]));
      chk($sformatf("cout_d%0d", 1 << g), 32'(cout_v[g]), 32'(e16[16]));
      chk($sformatf("ovf_d%0d", 1 << g), 32'(ovf_v[g]), 32'(e16[17]));
    end
    e8 = ref8(a8, b8, cin, sub8 & SUB_EN);
    chk("lat_w8", 32'(lat[5]), 32'd4);
    chk("sum_w8", 32'(sum8), 32'(e8[7:0]));
    chk("cout_w8", 32'(cout8), 32'(e8[8]));
    chk("ovf_w8", 32'(ovf8), 32'(e8[9]));
  endtask

  initial begin : main
    logic [15:0] x1, y1, x2, y2;
    logic [17:0] e1, e2;
    int          n2, t1, t2, t0, ndone;
    logic [15:0] s1, s2, s0;

    // reset state
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rst_busy", 32'(busy_v[g]), 32'd0);
      chk("rst_done", 32'(done_v[g]), 32'd0);
      chk("rst_sum", 32'(sum_v[g]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed cases
    run_op(16'h1234, 16'h4321, 1'b0, 8'h05, 8'h07, 1'b1);
    chk("dir_5555_sum", 32'(sum_v[0]), 32'h5555);
    chk("dir_5555_cout", 32'(cout_v[0]), 32'd0);
    chk("dir_5555_ovf", 32'(ovf_v[0]), 32'd0);
`ifdef ADDER_SUB_EN
    chk("dir_sub_fe_sum", 32'(sum8), 32'hFE);
    chk("dir_sub_fe_cout", 32'(cout8), 32'd0);
    chk("dir_sub_fe_ovf", 32'(ovf8), 32'd0);
`endif

    run_op(16'hFFFF, 16'h0001, 1'b0, 8'h80, 8'h01, 1'b1);
    chk("dir_wrap_sum", 32'(sum_v[2]), 32'h0000);
    chk("dir_wrap_cout", 32'(cout_v[2]), 32'd1);
    chk("dir_wrap_ovf", 32'(ovf_v[2]), 32'd0);
`ifdef ADDER_SUB_EN
    chk("dir_sub_7f_sum", 32'(sum8), 32'h7F);
    chk("dir_sub_7f_ovf", 32'(ovf8), 32'd1);
`endif

    run_op(16'h7FFF, 16'h0001, 1'b0, 8'h7F, 8'h01, 1'b0);
    chk("dir_ovf_sum", 32'(sum_v[2]), 32'h8000);
    chk("dir_ovf_flag", 32'(ovf_v[2]), 32'd1);
    chk("dir_w8_ovf", 32'(ovf8), 32'd1);

    // back-to-back: start held high, operands change while busy
    x1 = 16'($urandom); y1 = 16'($urandom);
    x2 = 16'($urandom); y2 = 16'($urandom);
    a = x1; b = y1; cin = 1'b0; sub8 = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = x2; b = y2;
    n2 = 0; t1 = 0; t2 = 0; t0 = 0; s1 = '0; s2 = '0; s0 = '0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) start = 1'b0;
      if (done_v[2]) begin
        if (n2 == 0) begin t1 = k; s1 = sum_v[2]; end
        else if (n2 == 1) begin t2 = k; s2 = sum_v[2]; end
        n2++;
      end
      if (done_v[0] && t0 == 0) begin t0 = k; s0 = sum_v[0]; end
    end
    e1 = ref16(x1, y1, 1'b0);
    e2 = ref16(x2, y2, 1'b0);
    chk("b2b_first_t", 32'(t1), 32'd4);
    chk("b2b_second_t", 32'(t2), 32'd9);
    chk("b2b_count", 32'(n2), 32'd2);
    chk("b2b_first_sum", 32'(s1), 32'(e1[15:0]));
    chk("b2b_second_sum", 32'(s2), 32'(e2[15:0]));
    chk("b2b_ignored_t", 32'(t0), 32'd16);
    chk("b2b_ignored_sum", 32'(s0), 32'(e1[15:0]));

    // reset at step 3 of 8 (DIGIT=2 instance)
    a = 16'($urandom) | 16'h0101; b = 16'($urandom); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_v[1]), 32'd0);
    chk("mid_rst_done", 32'(done_v[1]), 32'd0);
    chk("mid_rst_sum", 32'(sum_v[1]), 32'd0);
    chk("mid_rst_cout", 32'(cout_v[1]), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_v[1]), 32'd0);
    chk("mid_rst_sum_d1", 32'(sum_v[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 5; g++) if (done_v[g]) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    run_op(16'($urandom), 16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);

    // randomised sweep
    for (int n = 0; n < 1000; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
